// File: rtl/cordic_dds_pkg.sv
// Shared constants, tag/fold types and helpers for the CORDIC DDS sample scheduler.
package cordic_dds_pkg;

  localparam logic [15:0] PHASE_MOD = 16'd36000;
  localparam logic [15:0] Q1        = 16'd9000;
  localparam logic [15:0] Q2        = 16'd18000;
  localparam logic [15:0] Q3        = 16'd27000;
  localparam int          TAG_CH_W  = 3;   // covers up to 8 channels

  typedef struct packed {
    logic                valid;
    logic [TAG_CH_W-1:0] ch;
    logic                sneg;
    logic                cneg;
  } tag_t;

  typedef struct packed {
    logic [15:0] angle;
    logic        sneg;
    logic        cneg;
  } fold_t;

  function automatic fold_t fold(input logic [15:0] p);
    fold_t f;
    if (p <= Q1) begin
      f.angle = p;             f.sneg = 1'b0; f.cneg = 1'b0;
    end else if (p <= Q2) begin
      f.angle = Q2 - p;        f.sneg = 1'b0; f.cneg = 1'b1;
    end else if (p <= Q3) begin
      f.angle = p - Q2;        f.sneg = 1'b1; f.cneg = 1'b1;
    end else begin
      f.angle = PHASE_MOD - p; f.sneg = 1'b1; f.cneg = 1'b0;
    end
    return f;
  endfunction

  // -128 has no positive twin in 8 bits, so its negation clamps to +127.
  function automatic logic [7:0] neg_sat(input logic [7:0] v);
    return (v == 8'h80) ? 8'h7f : (~v + 8'd1);
  endfunction

endpackage

// File: rtl/cordic_dds_sched_tag_pipe.sv
// Fixed-depth shift register carrying sample tags alongside the shared CORDIC core.
module cordic_tag_pipe
  import cordic_dds_pkg::*;
#(
  parameter int DEPTH = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t pipe_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/cordic_dds_sched.sv
// Multi-channel DDS scheduler: per-channel phase accumulators, round-robin issue
// into one shared CORDIC core, sign-corrected tagged sample output.
module cordic_dds_sched #(
  parameter  int N_CH       = 4,
  parameter  int CORDIC_LAT = 18,
  parameter  int PHASE_MOD  = 36000,
  localparam int CH_W       = $clog2(N_CH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cfg_we_i,
  input  logic [CH_W-1:0] cfg_ch_i,
  input  logic            cfg_en_i,
  input  logic [15:0]     cfg_fcw_i,
  input  logic [15:0]     cfg_phase_i,
  output logic            cfg_err_o,
  input  logic [N_CH-1:0] req_i,
  output logic [N_CH-1:0] req_ovf_o,
  output logic            cor_start_o,
  output logic [15:0]     cor_angle_o,
  input  logic [7:0]      cor_sin_i,
  input  logic [7:0]      cor_cos_i,
  output logic            smp_valid_o,
  output logic [CH_W-1:0] smp_ch_o,
  output logic [7:0]      smp_sin_o,
  output logic [7:0]      smp_cos_o
);
  import cordic_dds_pkg::*;

  logic [15:0]     phase_q [N_CH];
  logic [15:0]     phase_d [N_CH];
  logic [15:0]     fcw_q   [N_CH];
  logic [15:0]     fcw_d   [N_CH];
  logic [N_CH-1:0] en_q, en_d, pend_q, pend_d, ovf_q, ovf_d;
  logic [CH_W-1:0] last_q, last_d;
  logic [15:0]     angle_q, angle_d;
  tag_t            tag_q, tag_d, tag_out;
  logic            cfg_err_q, cfg_err_d, start_q;
  logic            smp_valid_q;
  logic [CH_W-1:0] smp_ch_q;
  logic [7:0]      smp_sin_q, smp_cos_q;

  logic            gnt_vld;
  logic [CH_W-1:0] gnt_ch;
  fold_t           fold_g;
  logic [16:0]     sum_g;
  logic            cfg_bad;

  // Round-robin: scan downward so the channel nearest after last_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    for (int k = N_CH; k >= 1; k--) begin
      if (pend_q[CH_W'((int'(last_q) + k) % N_CH)]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'((int'(last_q) + k) % N_CH);
      end
    end
  end

  always_comb begin
    phase_d   = phase_q;
    fcw_d     = fcw_q;
    en_d      = en_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    last_d    = last_q;
    angle_d   = angle_q;
    tag_d     = '0;
    cfg_err_d = 1'b0;
    fold_g    = fold(phase_q[gnt_ch]);
    sum_g     = {1'b0, phase_q[gnt_ch]} + {1'b0, fcw_q[gnt_ch]};
    cfg_bad   = (cfg_fcw_i >= 16'(PHASE_MOD)) || (cfg_phase_i >= 16'(PHASE_MOD));

    if (gnt_vld) begin
      angle_d         = fold_g.angle;
      tag_d.valid     = 1'b1;
      tag_d.ch        = TAG_CH_W'(gnt_ch);
      tag_d.sneg      = fold_g.sneg;
      tag_d.cneg      = fold_g.cneg;
      phase_d[gnt_ch] = (sum_g >= 17'(PHASE_MOD)) ? 16'(sum_g - 17'(PHASE_MOD)) : sum_g[15:0];
      pend_d[gnt_ch]  = 1'b0;
      last_d          = gnt_ch;
    end

    for (int i = 0; i < N_CH; i++) begin
      if (req_i[i] && en_q[i]) begin
        if (pend_q[i] && !(gnt_vld && gnt_ch == CH_W'(i))) ovf_d[i]  = 1'b1;
        else                                               pend_d[i] = 1'b1;
      end
    end

    // A config write lands last so it overrides both the accumulator step and request capture.
    if (cfg_we_i) begin
      if (cfg_bad) begin
        cfg_err_d = 1'b1;
      end else begin
        en_d[cfg_ch_i]    = cfg_en_i;
        fcw_d[cfg_ch_i]   = cfg_fcw_i;
        phase_d[cfg_ch_i] = cfg_phase_i;
        pend_d[cfg_ch_i]  = 1'b0;
        ovf_d[cfg_ch_i]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CH; i++) begin
        phase_q[i] <= '0;
        fcw_q[i]   <= '0;
      end
      en_q      <= '0;
      pend_q    <= '0;
      ovf_q     <= '0;
      last_q    <= CH_W'(N_CH - 1);
      angle_q   <= '0;
      tag_q     <= '0;
      cfg_err_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      fcw_q     <= fcw_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      last_q    <= last_d;
      angle_q   <= angle_d;
      tag_q     <= tag_d;
      cfg_err_q <= cfg_err_d;
      start_q   <= 1'b1;
    end
  end

  // tag_q is registered with cor_angle, so the line output meets the core result.
  cordic_tag_pipe #(.DEPTH(CORDIC_LAT)) u_tag_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tag_i (tag_q),
    .tag_o (tag_out)
  );

  // A tag naming a channel beyond N_CH can never be issued, so it never counts as a sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      smp_valid_q <= 1'b0;
      smp_ch_q    <= '0;
      smp_sin_q   <= '0;
      smp_cos_q   <= '0;
    end else begin
      smp_valid_q <= tag_out.valid && (int'(tag_out.ch) < N_CH);
      if (tag_out.valid) begin
        smp_ch_q  <= CH_W'(tag_out.ch);
        smp_sin_q <= tag_out.sneg ? neg_sat(cor_sin_i) : cor_sin_i;
        smp_cos_q <= tag_out.cneg ? neg_sat(cor_cos_i) : cor_cos_i;
      end
    end
  end

  assign cfg_err_o   = cfg_err_q;
  assign req_ovf_o   = ovf_q;
  assign cor_start_o = start_q;
  assign cor_angle_o = angle_q;
  assign smp_valid_o = smp_valid_q;
  assign smp_ch_o    = smp_ch_q;
  assign smp_sin_o   = smp_sin_q;
  assign smp_cos_o   = smp_cos_q;

endmodule
